// File: rtl/ack_pkg.sv
// rtl/ack_pkg.sv - shared source IDs, FSM encoding and round-robin helper for the ACK path
//
// Purpose: constants shared between the ACK request scheduler and the ACK bus
// arbiter, so both sides agree on source numbering.
// Ports: none (package).

package ack_pkg;

  localparam int SRC_N = 4;

  localparam logic [1:0] ID_MEM  = 2'd0;
  localparam logic [1:0] ID_SHA  = 2'd1;
  localparam logic [1:0] ID_AES  = 2'd2;
  localparam logic [1:0] ID_CTRL = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // First pending source at or after ptr (wrapping mod 4). Walking the
  // offsets from the far end down lets the nearest pending source overwrite
  // any later one. Returns ptr when nothing is pending; callers gate on |pend.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                         input logic [SRC_N-1:0] pend);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = SRC_N - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/ack_src_counter.sv
// rtl/ack_src_counter.sv - saturating pending-ACK counter with sticky overflow flag
//
// Purpose: counts outstanding ACKs for one source.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc          completion pulse from the source
//   dec          grant retiring one pending ACK
//   hold         freeze the counter and flag this cycle (protocol error)
//   cnt          registered count
//   cnt_next     count that will be registered at the next edge
//   overflow     sticky: a completion arrived while the counter was full

module ack_src_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (!hold) begin
      if (inc && !dec) begin
        // A full counter drops the event rather than wrapping.
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;
  assign overflow = ovf_q;

endmodule

// File: rtl/ack_req_scheduler.sv
// rtl/ack_req_scheduler.sv - round-robin per-source ACK request scheduler
//
// Purpose: collects completion pulses into per-source pending counters and
// presents one registered request at a time to the fixed-priority ACK
// arbiter, rotating between sources so none starves.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   done_{mem,sha,aes,ctrl}         single-cycle completion pulses
//   req_{mem,sha,aes,ctrl}          registered one-hot request to the arbiter
//   ack_ready_to_{mem,sha,aes,ctrl} one-hot grant from the arbiter
//   ack_event                       arbiter grant event
//   winner_source_id                arbiter winner (MEM=0 SHA=1 AES=2 CTRL=3)
//   busy                            any pending counter nonzero
//   overflow[3:0]                   sticky per-source saturation flag
//   protocol_err                    sticky grant-consistency error

module ack_req_scheduler #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done_mem,
  input  logic       done_sha,
  input  logic       done_aes,
  input  logic       done_ctrl,
  output logic       req_mem,
  output logic       req_sha,
  output logic       req_aes,
  output logic       req_ctrl,
  input  logic       ack_ready_to_mem,
  input  logic       ack_ready_to_sha,
  input  logic       ack_ready_to_aes,
  input  logic       ack_ready_to_ctrl,
  input  logic       ack_event,
  input  logic [1:0] winner_source_id,
  output logic       busy,
  output logic [3:0] overflow,
  output logic       protocol_err
);

  import ack_pkg::*;

  logic [SRC_N-1:0] done_v, ready_v, grant_v;
  logic [SRC_N-1:0] pend_q, pend_d, ovf_v;
  logic [CNT_W-1:0] cnt_cur [SRC_N];
  logic [CNT_W-1:0] cnt_nxt [SRC_N];

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       rr_q, rr_d;
  logic [SRC_N-1:0] req_q, req_d;
  logic             perr_q, perr_d;
  logic             err_now, grant_any;

  assign done_v  = {done_ctrl, done_aes, done_sha, done_mem};
  assign ready_v = {ack_ready_to_ctrl, ack_ready_to_aes, ack_ready_to_sha, ack_ready_to_mem};

  // In IDLE sel_q is stale, so any ack_event there is already an error on
  // its own; the winner mismatch check only matters in REQ.
  assign err_now = (ack_event && (state_q == IDLE))
                 || (ack_event && (winner_source_id != sel_q))
                 || (|(ready_v & ~req_q));

  // A grant is suppressed whenever the cycle is erroneous so counters and
  // FSM stay frozen together.
  assign grant_v   = err_now ? '0 : (req_q & ready_v & {SRC_N{ack_event}});
  assign grant_any = |grant_v;

  for (genvar i = 0; i < SRC_N; i++) begin : g_cnt
    ack_src_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (done_v[i]),
      .dec      (grant_v[i]),
      .hold     (err_now),
      .cnt      (cnt_cur[i]),
      .cnt_next (cnt_nxt[i]),
      .overflow (ovf_v[i])
    );
    assign pend_q[i] = (cnt_cur[i] != '0);
    assign pend_d[i] = (cnt_nxt[i] != '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= ID_MEM;
      rr_q    <= ID_MEM;
      req_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic. Selection uses next-state counts so a done pulse in
  // this cycle can be requested in the very next one.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    if (!err_now) begin
      if (state_q == IDLE) begin
        if (|pend_d) begin
          sel_d   = rr_pick(rr_q, pend_d);
          state_d = REQ;
        end
      end else if (grant_any) begin
        // sel stays put until its grant, regardless of new lower-ID work.
        rr_d = sel_q + 2'd1;
        if (|pend_d) begin
          sel_d   = rr_pick(sel_q + 2'd1, pend_d);
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // Output logic: request register loads the decode of the next state.
  always_comb begin
    req_d = '0;
    if (state_d == REQ) req_d[sel_d] = 1'b1;
    perr_d = perr_q | err_now;
  end

  assign req_mem      = req_q[ID_MEM];
  assign req_sha      = req_q[ID_SHA];
  assign req_aes      = req_q[ID_AES];
  assign req_ctrl     = req_q[ID_CTRL];
  assign busy         = |pend_q;
  assign overflow     = ovf_v;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_ack_req_scheduler.sv
// tb/tb_ack_req_scheduler.sv - directed self-checking bench for ack_req_scheduler

module tb_ack_req_scheduler;

  logic       clk;
  logic       rst_n;
  logic       done_mem, done_sha, done_aes, done_ctrl;
  logic       req_mem, req_sha, req_aes, req_ctrl;
  logic       ack_ready_to_mem, ack_ready_to_sha, ack_ready_to_aes, ack_ready_to_ctrl;
  logic       ack_event;
  logic [1:0] winner_source_id;
  logic       busy;
  logic [3:0] overflow;
  logic       protocol_err;
  logic [3:0] req_v;

  int errors = 0;
  int checks = 0;

  ack_req_scheduler #(.CNT_W(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .done_mem          (done_mem),
    .done_sha          (done_sha),
    .done_aes          (done_aes),
    .done_ctrl         (done_ctrl),
    .req_mem           (req_mem),
    .req_sha           (req_sha),
    .req_aes           (req_aes),
    .req_ctrl          (req_ctrl),
    .ack_ready_to_mem  (ack_ready_to_mem),
    .ack_ready_to_sha  (ack_ready_to_sha),
    .ack_ready_to_aes  (ack_ready_to_aes),
    .ack_ready_to_ctrl (ack_ready_to_ctrl),
    .ack_event         (ack_event),
    .winner_source_id  (winner_source_id),
    .busy              (busy),
    .overflow          (overflow),
    .protocol_err      (protocol_err)
  );

  assign req_v = {req_ctrl, req_aes, req_sha, req_mem};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_grant();
    ack_ready_to_mem  = 1'b0;
    ack_ready_to_sha  = 1'b0;
    ack_ready_to_aes  = 1'b0;
    ack_ready_to_ctrl = 1'b0;
    ack_event         = 1'b0;
    winner_source_id  = 2'd0;
  endtask

  task automatic clear_in();
    done_mem  = 1'b0;
    done_sha  = 1'b0;
    done_aes  = 1'b0;
    done_ctrl = 1'b0;
    clear_grant();
  endtask

  task automatic apply_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Acts as a well-behaved arbiter granting source id for one cycle.
  task automatic drive_grant(input int id);
    ack_ready_to_mem  = (id == 0);
    ack_ready_to_sha  = (id == 1);
    ack_ready_to_aes  = (id == 2);
    ack_ready_to_ctrl = (id == 3);
    ack_event         = 1'b1;
    winner_source_id  = 2'(id);
    tick();
    clear_grant();
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0;
    #3;
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b expected %b", req_v, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b expected 0000", overflow); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    done_sha = 1'b1;
    tick();
    done_sha = 1'b0;
    checks++; if (req_v !== 4'b0010) begin errors++; $display("FAIL single_req: got %b expected %b", req_v, 4'b0010); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    drive_grant(1);
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL single_req_after: got %b expected %b", req_v, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL single_perr: got %b expected 0", protocol_err); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp;
    apply_reset();
    done_mem = 1'b1; done_sha = 1'b1; done_aes = 1'b1; done_ctrl = 1'b1;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      exp = 4'b0001 << i;
      checks++; if (req_v !== exp) begin errors++; $display("FAIL all4_req%0d: got %b expected %b", i, req_v, exp); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all4_busy%0d: got %b expected 1", i, busy); end
      drive_grant(i);
    end
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL all4_req_end: got %b expected 0000", req_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all4_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_starvation();
    logic [3:0] exp_req [4];
    int         exp_id  [4];
    exp_req = '{4'b0001, 4'b0100, 4'b0001, 4'b0001};
    exp_id  = '{0, 2, 0, 0};
    apply_reset();
    done_mem = 1'b1;
    done_aes = 1'b1;
    tick();
    done_aes = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_v !== exp_req[i]) begin errors++; $display("FAIL starve_req%0d: got %b expected %b", i, req_v, exp_req[i]); end
      drive_grant(exp_id[i]);
    end
    done_mem = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (req_v !== 4'b0001) begin errors++; $display("FAIL starve_drain%0d: got %b expected 0001", i, req_v); end
      drive_grant(0);
    end
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL starve_req_end: got %b expected 0000", req_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_busy_end: got %b expected 0", busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL starve_perr: got %b expected 0", protocol_err); end
  endtask

  task automatic test_overflow();
    apply_reset();
    done_mem = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    done_mem = 1'b0;
    checks++; if (overflow !== 4'b0001) begin errors++; $display("FAIL ovf_flag: got %b expected 0001", overflow); end
    checks++; if (req_v !== 4'b0001) begin errors++; $display("FAIL ovf_req: got %b expected 0001", req_v); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_v !== 4'b0001) begin errors++; $display("FAIL ovf_grant%0d: got %b expected 0001", i, req_v); end
      drive_grant(0);
    end
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL ovf_req_end: got %b expected 0000", req_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end: got %b expected 0", busy); end
    checks++; if (overflow !== 4'b0001) begin errors++; $display("FAIL ovf_sticky: got %b expected 0001", overflow); end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    done_sha = 1'b1;
    tick();
    done_sha = 1'b0;
    checks++; if (req_v !== 4'b0010) begin errors++; $display("FAIL perr_setup_req: got %b expected 0010", req_v); end
    ack_event        = 1'b1;
    winner_source_id = 2'd2;
    done_mem         = 1'b1;
    tick();
    clear_in();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_winner: got %b expected 1", protocol_err); end
    checks++; if (req_v !== 4'b0010) begin errors++; $display("FAIL perr_req_hold: got %b expected 0010", req_v); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL perr_busy: got %b expected 1", busy); end
    drive_grant(1);
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL perr_cnt_frozen: got %b expected 0000", req_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perr_busy_after: got %b expected 0", busy); end
    apply_reset();
    ack_ready_to_ctrl = 1'b1;
    tick();
    clear_in();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_ready_no_req: got %b expected 1", protocol_err); end
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL perr_ready_req: got %b expected 0000", req_v); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    done_ctrl = 1'b1;
    tick();
    tick();
    done_ctrl = 1'b0;
    checks++; if (req_v !== 4'b1000) begin errors++; $display("FAIL midrst_setup: got %b expected 1000", req_v); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL midrst_req: got %b expected 0000", req_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL midrst_ovf: got %b expected 0000", overflow); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b expected 0", protocol_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_v !== 4'b0000) begin errors++; $display("FAIL midrst_quiet%0d: got %b expected 0000", i, req_v); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet_busy%0d: got %b expected 0", i, busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_single();
    test_all_four();
    test_starvation();
    test_overflow();
    test_protocol_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
